mix_columns_iter: RTL

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

---
 rtl/aes_pkg.sv | 17 +
 rtl/xtime.sv | 14 +
 rtl/mix_columns_iter.sv | 110 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative MixColumns block.
//   mc_state_t   : controller states (IDLE, BUSY, DONE)
//   AES_POLY_RED : low byte of the GF(2^8) reduction polynomial 0x11B
//   aes_state_t  : one 128-bit AES state
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  localparam logic [7:0] AES_POLY_RED = 8'h1B;

  typedef logic [127:0] aes_state_t;

endpackage

// File: rtl/xtime.sv
// GF(2^8) multiply-by-2 (AES xtime), purely combinational.
//   in_byte  : operand byte
//   out_byte : in_byte * 2, reduced modulo 0x11B
module xtime
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Shift left; fold the bit shifted out of position 7 back in via 0x1B.
  assign out_byte = {in_byte[6:0], 1'b0} ^ (in_byte[7] ? AES_POLY_RED : 8'h00);

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES forward MixColumns: one column per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid / in_ready / in_state    : input handshake and ShiftRows output
//   out_valid / out_ready / out_state : result handshake and MixColumns output
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready is 1 only in IDLE, out_valid is 1 only in DONE; both come
// straight from the state register, and out_state is held until taken.
// Column c occupies state[127-32c -: 32], row 0 in its most significant byte.
module mix_columns_iter
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state
);

  mc_state_t  state, state_nxt;
  logic [1:0] col;
  aes_state_t work, result;

  logic [31:0] col_in, col_out;
  logic [7:0]  a  [4];
  logic [7:0]  x2 [4];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)    state_nxt = BUSY;
      BUSY:    if (col == 2'd3) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_state = result;

  // ---------------- active column datapath ----------------
  always_comb begin
    case (col)
      2'd0:    col_in = work[127:96];
      2'd1:    col_in = work[95:64];
      2'd2:    col_in = work[63:32];
      default: col_in = work[31:0];
    endcase
  end

  assign a[0] = col_in[31:24];
  assign a[1] = col_in[23:16];
  assign a[2] = col_in[15:8];
  assign a[3] = col_in[7:0];

  for (genvar i = 0; i < 4; i++) begin : g_xtime
    xtime u_xtime (
      .in_byte  (a[i]),
      .out_byte (x2[i])
    );
  end

  // 3x = 2x ^ x, so each row is the XOR of two doubled bytes and three plain ones.
  assign col_out[31:24] = x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3];
  assign col_out[23:16] = a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3];
  assign col_out[15:8]  = a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3];
  assign col_out[7:0]   = x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3];

  // ---------------- working / result registers ----------------
  // Capture is a private copy, so in_state may change freely after acceptance.
  // col is 2 bits wide, so the step after column 3 wraps to 0 by itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= 2'd0;
      work   <= '0;
      result <= '0;
    end else if (state == IDLE && in_valid) begin
      work <= in_state;
      col  <= 2'd0;
    end else if (state == BUSY) begin
      case (col)
        2'd0:    result[127:96] <= col_out;
        2'd1:    result[95:64]  <= col_out;
        2'd2:    result[63:32]  <= col_out;
        default: result[31:0]   <= col_out;
      endcase
      col <= col + 2'd1;
    end
  end

endmodule
